// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller.
// Size codes match the ones consumed by mask_MemReadM.
package dmem_access_ctrl_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P_RD = 2'd1,
        D_RD = 2'd2
    } state_e;

    // Size code 3 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_BYTE: return 1'b0;
            default: return (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline, debug and memory-side signals of the data-memory access controller.
interface dmem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              p_req;
    logic              p_we;
    logic [31:0]       p_addr;
    logic [1:0]        p_size;
    logic [31:0]       p_wdata;
    logic [31:0]       p_rdata;
    logic              p_valid;
    logic              p_stall;
    logic              p_misalign;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_rdata;
    logic              d_ack;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_size, p_wdata,
        output p_rdata, p_valid, p_stall, p_misalign,
        input  d_req, d_addr,
        output d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_size, p_wdata,
        input  p_rdata, p_valid, p_stall, p_misalign,
        output d_req, d_addr,
        input  d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Store byte-enable generation with lane replication, and load right-alignment.
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_data_o,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    always_comb begin
        st_be_o   = 4'b1111;
        st_data_o = st_data_i;
        case (st_size_i)
            SZ_HALF: begin
                st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            SZ_BYTE: begin
                st_be_o   = 4'b0001 << st_off_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            default: ;
        endcase
    end

    // Upper bits keep raw lane data; sign/zero extension happens downstream.
    assign ld_data_o = ld_raw_i >> {ld_off_i, 3'b000};

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-port data-memory access controller: arbitrates pipeline vs. debug,
// sequences the 1-cycle synchronous read and stalls the MEM stage as needed.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_access_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [1:0]      off_q, off_d;
    logic [3:0]      st_be;
    logic [31:0]     st_data;
    logic [31:0]     ld_data;
    logic            misaligned;
    logic            d_force;
    logic            d_grant;

    dmem_lane_align u_align (
        .st_size_i (bus.p_size),
        .st_off_i  (bus.p_addr[1:0]),
        .st_data_i (bus.p_wdata),
        .st_be_o   (st_be),
        .st_data_o (st_data),
        .ld_off_i  (off_q),
        .ld_raw_i  (bus.mem_rdata),
        .ld_data_o (ld_data)
    );

    assign misaligned = is_misaligned(bus.p_size, bus.p_addr[1:0]);
    assign d_force    = bus.d_req && (wcnt_q == CW'(MAX_WAIT));

    // Outputs are gated by rst_n so they drop to 0 as soon as reset asserts.
    always_comb begin
        state_d        = state_q;
        off_d          = off_q;
        d_grant        = 1'b0;
        bus.p_rdata    = '0;
        bus.p_valid    = 1'b0;
        bus.p_stall    = 1'b0;
        bus.p_misalign = 1'b0;
        bus.d_rdata    = '0;
        bus.d_ack      = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (d_force || (!bus.p_req && bus.d_req)) begin
                        d_grant      = 1'b1;
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = bus.d_addr;
                        bus.p_stall  = bus.p_req;
                        state_d      = D_RD;
                    end else if (bus.p_req) begin
                        if (misaligned) begin
                            bus.p_misalign = 1'b1;
                        end else if (bus.p_we) begin
                            bus.mem_en    = 1'b1;
                            bus.mem_we    = st_be;
                            bus.mem_wdata = st_data;
                            bus.mem_addr  = bus.p_addr[ADDR_W+1:2];
                        end else begin
                            bus.mem_en   = 1'b1;
                            bus.mem_addr = bus.p_addr[ADDR_W+1:2];
                            bus.p_stall  = 1'b1;
                            off_d        = bus.p_addr[1:0];
                            state_d      = P_RD;
                        end
                    end
                end
                P_RD: begin
                    bus.p_valid = 1'b1;
                    bus.p_rdata = ld_data;
                    state_d     = IDLE;
                end
                D_RD: begin
                    bus.d_ack   = 1'b1;
                    bus.d_rdata = bus.mem_rdata;
                    bus.p_stall = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        wcnt_d = wcnt_q;
        if (d_grant) begin
            wcnt_d = '0;
        end else if (bus.d_req && (wcnt_q != CW'(MAX_WAIT))) begin
            wcnt_d = wcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            off_q   <= off_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a behavioural synchronous memory.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];

    // Preloaded while in reset; one-cycle synchronous read otherwise.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[2]  <= 32'h0000_0000;
            mem[3]  <= 32'h0000_0000;
            mem[4]  <= 32'hBEEF_1234;
            mem[7]  <= 32'h1357_9BDF;
            mem[8]  <= 32'hCAFE_F00D;
            mem[12] <= 32'h0000_0000;
        end else if (bus.mem_en) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            for (int b = 0; b < 4; b++)
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [3:0]        we;
        logic [31:0]       d;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pq [$];
    logic [31:0] dq [$];
    wr_t         wq [$];
    logic        mq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.p_valid) begin
                if (pq.size() == 0) chk("p_valid_unexpected", 32'(bus.p_valid), 32'd0);
                else chk("p_rdata", bus.p_rdata, pq.pop_front());
            end
            if (bus.d_ack) begin
                if (dq.size() == 0) chk("d_ack_unexpected", 32'(bus.d_ack), 32'd0);
                else chk("d_rdata", bus.d_rdata, dq.pop_front());
            end
            if (bus.mem_en && (bus.mem_we != 4'b0000)) begin
                if (wq.size() == 0) chk("write_unexpected", 32'(bus.mem_we), 32'd0);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("mem_addr_wr", 32'(bus.mem_addr), 32'(w.a));
                    chk("mem_we", 32'(bus.mem_we), 32'(w.we));
                    chk("mem_wdata", bus.mem_wdata, w.d);
                end
            end
            if (bus.p_misalign) begin
                if (mq.size() == 0) chk("misalign_unexpected", 32'(bus.p_misalign), 32'd0);
                else chk("p_misalign", 32'(bus.p_misalign), 32'(mq.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                            input logic [3:0] exp_we, input logic [31:0] exp_wd);
        wr_t w;
        w.a = addr[ADDR_W+1:2]; w.we = exp_we; w.d = exp_wd;
        wq.push_back(w);
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = addr; bus.p_size = size; bus.p_wdata = wd;
        @(negedge clk);
        chk("store_stall", 32'(bus.p_stall), 32'd0);
        step();
        bus.p_req = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] exp);
        pq.push_back(exp);
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = addr; bus.p_size = size;
        @(negedge clk);
        chk("load_grant_stall", 32'(bus.p_stall), 32'd1);
        chk("load_grant_en", 32'({bus.mem_en, bus.mem_we}), 32'h10);
        step();
        @(negedge clk);
        chk("load_rd_stall", 32'(bus.p_stall), 32'd0);
        step();
        bus.p_req = 1'b0;
    endtask

    task automatic do_mis(input logic [31:0] addr, input logic [1:0] size);
        mq.push_back(1'b1);
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = addr; bus.p_size = size;
        @(negedge clk);
        chk("mis_mem_en", 32'(bus.mem_en), 32'd0);
        chk("mis_stall", 32'(bus.p_stall), 32'd0);
        step();
        bus.p_req = 1'b0;
    endtask

    task automatic do_dbg(input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        logic got;
        got = 1'b0;
        dq.push_back(exp);
        bus.d_req = 1'b1; bus.d_addr = addr;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.d_ack) got = 1'b1;
            step();
        end
        bus.d_req = 1'b0;
        chk("dbg_ack_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int  arbs, dgrant_at;
        logic got_ack, done;
        bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_size = SZ_WORD; bus.p_wdata = '0;
        bus.d_req = 1'b0; bus.d_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl_outs", 32'({bus.mem_en, bus.mem_we, bus.p_valid, bus.p_stall, bus.p_misalign, bus.d_ack}), 32'd0);
        chk("rst_p_rdata", bus.p_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Simultaneous store and debug read with an empty wait counter.
        wq.push_back('{a: 10'd12, we: 4'b1111, d: 32'h1122_3344});
        dq.push_back(32'h1122_3344);
        bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = 32'h30; bus.p_size = SZ_WORD; bus.p_wdata = 32'h1122_3344;
        bus.d_req = 1'b1; bus.d_addr = 10'd12;
        @(negedge clk);
        chk("st_first_stall", 32'(bus.p_stall), 32'd0);
        step();
        bus.p_req = 1'b0;
        @(negedge clk);
        chk("dbg_next_en", 32'({bus.mem_en, bus.mem_we}), 32'h10);
        chk("dbg_next_addr", 32'(bus.mem_addr), 32'd12);
        step();
        @(negedge clk);
        chk("drd_stall", 32'(bus.p_stall), 32'd1);
        step();
        bus.d_req = 1'b0;

        do_load(32'h12, SZ_HALF, 32'h0000_BEEF);
        do_store(32'h13, SZ_BYTE, 32'h1234_56A5, 4'b1000, 32'hA5A5_A5A5);
        do_store(32'h0E, SZ_HALF, 32'hDEAD_7788, 4'b1100, 32'h7788_7788);
        do_store(32'h08, SZ_HALF, 32'h0000_CAFE, 4'b0011, 32'hCAFE_CAFE);
        do_load(32'h13, SZ_BYTE, 32'h0000_00A5);
        do_load(32'h11, SZ_BYTE, 32'h00A5_EF12);
        do_load(32'h0C, SZ_WORD, 32'h7788_0000);
        do_load(32'h0C, 2'd3,    32'h7788_0000);
        do_load(32'h08, SZ_HALF, 32'h0000_CAFE);
        do_mis(32'h06, SZ_WORD);
        do_mis(32'h21, SZ_HALF);
        do_mis(32'h0D, 2'd3);
        do_dbg(10'd4, 32'hA5EF_1234);

        // Debug request against a continuous stream of pipeline loads.
        dq.push_back(32'h1357_9BDF);
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h20; bus.p_size = SZ_WORD;
        bus.d_req = 1'b1; bus.d_addr = 10'd7;
        arbs = 0; dgrant_at = 0; got_ack = 1'b0; done = 1'b0;
        for (int i = 0; i < 24 && !done; i++) begin
            @(negedge clk);
            if (bus.mem_en) begin
                arbs++;
                if (bus.mem_addr == 10'd7) dgrant_at = arbs;
                else pq.push_back(32'hCAFE_F00D);
            end
            if (bus.d_ack) begin
                chk("drd_stall_busy", 32'(bus.p_stall), 32'd1);
                got_ack = 1'b1;
            end
            if (got_ack && bus.p_valid) done = 1'b1;
            step();
            if (got_ack) bus.d_req = 1'b0;
            if (done) bus.p_req = 1'b0;
        end
        bus.p_req = 1'b0; bus.d_req = 1'b0;
        chk("contention_done", 32'(done), 32'd1);
        chk("dbg_grant_bound", 32'((dgrant_at != 0) && (dgrant_at <= int'(MAX_WAIT) + 1)), 32'd1);
        step();

        // Reset while a pipeline load sits in P_RD.
        bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h12; bus.p_size = SZ_HALF;
        @(negedge clk);
        chk("rstmid_grant_stall", 32'(bus.p_stall), 32'd1);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_ctrl_outs", 32'({bus.mem_en, bus.mem_we, bus.p_valid, bus.p_stall, bus.p_misalign, bus.d_ack}), 32'd0);
        chk("rstmid_p_rdata", bus.p_rdata, 32'd0);
        step();
        bus.p_req = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("post_rst_stall", 32'(bus.p_stall), 32'd0);

        chk("pq_empty", 32'(pq.size()), 32'd0);
        chk("dq_empty", 32'(dq.size()), 32'd0);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("mq_empty", 32'(mq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
